// File: rtl/knight_move_sequencer_pkg.sv
// Knight geometry and sequencer state types shared by the move sequencer files (package chess_pkg).
package chess_pkg;

   localparam int NDIR  = 8;
   localparam int CNT_W = 4;

   typedef enum logic [2:0] {U2L1, U2R1, R2U1, R2D1, D2R1, D2L1, L2D1, L2U1} knight_dir_t;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} seq_state_t;

   localparam logic signed [3:0] KNIGHT_DROW [NDIR] =
      '{-4'sd2, -4'sd2, -4'sd1, 4'sd1, 4'sd2, 4'sd2, 4'sd1, -4'sd1};
   localparam logic signed [3:0] KNIGHT_DCOL [NDIR] =
      '{-4'sd1, 4'sd1, 4'sd2, 4'sd2, 4'sd1, -4'sd1, -4'sd2, -4'sd2};

   // 4-bit wrap-around add: any off-board result (-2..-1 or 8..9) lands with bit 3 set.
   function automatic logic [3:0] knight_step(input logic [2:0] base, input logic signed [3:0] delta);
      return {1'b0, base} + delta;
   endfunction

   function automatic logic [NDIR-1:0] knight_onboard(input logic [2:0] r, input logic [2:0] c);
      logic [NDIR-1:0] ok;
      logic [3:0]      tr;
      logic [3:0]      tc;
      ok = '0;
      for (int d = 0; d < NDIR; d++) begin
         tr    = knight_step(r, KNIGHT_DROW[d]);
         tc    = knight_step(c, KNIGHT_DCOL[d]);
         ok[d] = ~tr[3] & ~tc[3];
      end
      return ok;
   endfunction

endpackage

// File: rtl/knight_move_sequencer_if.sv
// Valid/ready stream carrying one knight target square per handshake.
interface knight_move_sequencer_if;
   logic                   move_valid;
   logic                   move_ready;
   chess_pkg::knight_dir_t move_dir;
   logic [2:0]             move_row;
   logic [2:0]             move_col;
   logic                   move_capture;

   modport master (output move_valid, move_dir, move_row, move_col, move_capture, input move_ready);
   modport slave  (input move_valid, move_dir, move_row, move_col, move_capture, output move_ready);
endinterface

// File: rtl/knight_move_sequencer_dir_pick.sv
// Lowest-set-bit priority encoder over the knight direction mask.
module knight_dir_pick
   import chess_pkg::*;
(
   input  logic [NDIR-1:0] req_i,
   output logic [2:0]      idx_o,
   output logic            any_o
);

   always_comb begin
      idx_o = '0;
      for (int i = NDIR - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = 3'(i);
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/knight_move_sequencer.sv
// Streams the legal knight target squares one per handshake.
// Optional KNIGHT_CAPTURE_FLAG_EN: flag targets that land on an occupied square.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SCAN  | presenting targets from the latched mask, one per accept
// DONE  | one-cycle done pulse, then back to IDLE
module knight_move_sequencer
   import chess_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       row,
   input  logic [2:0]       column,
   input  logic [NDIR-1:0]  knightAllow,
   input  logic             abort,
   input  logic [63:0]      occupied,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] move_count,
   knight_move_sequencer_if.master mv
);

   seq_state_t       state_q, state_d;
   logic [NDIR-1:0]  mask_q, mask_d;
   logic [2:0]       row_q, row_d, col_q, col_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   knight_dir_t      dir_q, dir_d;
   logic [2:0]       trow_q, trow_d, tcol_q, tcol_d;
   logic             cap_q, cap_d;

   logic [2:0]      src_row, src_col, pick_idx, tgt_row, tgt_col;
   logic [NDIR-1:0] src_mask;
   logic            pick_any, cap_pick, load, clr;

   // In IDLE the picker looks at the live inputs so the first target is ready on the start edge.
   assign src_row  = (state_q == IDLE) ? row    : row_q;
   assign src_col  = (state_q == IDLE) ? column : col_q;
   assign src_mask = (state_q == IDLE) ? (knightAllow & knight_onboard(row, column)) : mask_q;

   knight_dir_pick u_pick (
      .req_i (src_mask),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign tgt_row = 3'(knight_step(src_row, KNIGHT_DROW[pick_idx]));
   assign tgt_col = 3'(knight_step(src_col, KNIGHT_DCOL[pick_idx]));

`ifdef KNIGHT_CAPTURE_FLAG_EN
   assign cap_pick = occupied[{tgt_row, tgt_col}];
`else
   logic unused_occupied;
   assign unused_occupied = ^occupied;
   assign cap_pick        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      row_d   = row_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      dir_d   = dir_q;
      trow_d  = trow_q;
      tcol_d  = tcol_q;
      cap_d   = cap_q;
      load    = 1'b0;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               mask_d  = src_mask;
               row_d   = row;
               col_d   = column;
               cnt_d   = '0;
               load    = pick_any;
            end
         end
         SCAN: begin
            if (abort) begin
               state_d = IDLE;
               mask_d  = '0;
               clr     = 1'b1;
            end else if (valid_q) begin
               if (mv.move_ready) begin
                  mask_d = mask_q & ~(NDIR'(1) << dir_q);
                  cnt_d  = cnt_q + CNT_W'(1);
                  clr    = 1'b1;
               end
            end else if (pick_any) begin
               load = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clr) begin
         valid_d = 1'b0;
         dir_d   = U2L1;
         trow_d  = '0;
         tcol_d  = '0;
         cap_d   = 1'b0;
      end
      if (load) begin
         valid_d = 1'b1;
         dir_d   = knight_dir_t'(pick_idx);
         trow_d  = tgt_row;
         tcol_d  = tgt_col;
         cap_d   = cap_pick;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         dir_q   <= U2L1;
         trow_q  <= '0;
         tcol_q  <= '0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         row_q   <= row_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         dir_q   <= dir_d;
         trow_q  <= trow_d;
         tcol_q  <= tcol_d;
         cap_q   <= cap_d;
      end
   end

   assign busy            = (state_q != IDLE);
   assign done            = (state_q == DONE);
   assign move_count      = cnt_q;
   assign mv.move_valid   = valid_q;
   assign mv.move_dir     = dir_q;
   assign mv.move_row     = trow_q;
   assign mv.move_col     = tcol_q;
   assign mv.move_capture = cap_q;

endmodule

// File: tb/tb_knight_move_sequencer.sv
// Directed bench for knight_move_sequencer: table of full scans plus hold, abort and reset sequences.
module tb_knight_move_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  row;
   logic [2:0]  column;
   logic [7:0]  knightAllow;
   logic        abort;
   logic [63:0] occupied;
   logic        busy;
   logic        done;
   logic [3:0]  move_count;

   knight_move_sequencer_if mv_if ();

   knight_move_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .row         (row),
      .column      (column),
      .knightAllow (knightAllow),
      .abort       (abort),
      .occupied    (occupied),
      .busy        (busy),
      .done        (done),
      .move_count  (move_count),
      .mv          (mv_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] r;
      logic [2:0] c;
      logic [7:0] allow;
      int         n;
      int         donecyc;
      logic [2:0] dirs [8];
      logic [5:0] tgts [8];
   } vec_t;

   vec_t vecs [6];
   int   npass = 0;
   int   ntot  = 0;

   task automatic chk(input string name, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_cap(input logic [5:0] t);
`ifdef KNIGHT_CAPTURE_FLAG_EN
      return (t == 6'o23) ? 1 : 0;
`else
      return (t == 6'o77) ? 0 : 0;
`endif
   endfunction

   function automatic int cur_tgt();
      return int'({mv_if.move_row, mv_if.move_col});
   endfunction

   task automatic run_scan(input int vi);
      vec_t v;
      int   k;
      bit   seen_done;
      v = vecs[vi];
      row = v.r; column = v.c; knightAllow = v.allow;
      mv_if.move_ready = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0; knightAllow = 8'h00; row = ~v.r; column = ~v.c;
      k = 0;
      seen_done = 1'b0;
      for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
         if (mv_if.move_valid) begin
            if (k < v.n) begin
               chk($sformatf("v%0d dir[%0d]", vi, k), int'(mv_if.move_dir), int'(v.dirs[k]));
               chk($sformatf("v%0d tgt[%0d] (octal rc)", vi, k), cur_tgt(), int'(v.tgts[k]));
               chk($sformatf("v%0d cap[%0d]", vi, k), int'(mv_if.move_capture), exp_cap(v.tgts[k]));
            end else begin
               chk($sformatf("v%0d extra move", vi), 1, 0);
            end
            k++;
         end
         if (done) begin
            seen_done = 1'b1;
            chk($sformatf("v%0d done cycle", vi), cyc, v.donecyc);
            chk($sformatf("v%0d move_count", vi), int'(move_count), v.n);
         end else begin
            tick;
         end
      end
      chk($sformatf("v%0d moves seen", vi), k, v.n);
      chk($sformatf("v%0d done seen", vi), int'(seen_done), 1);
      tick;
      chk($sformatf("v%0d done one cycle", vi), int'(done), 0);
      chk($sformatf("v%0d idle busy", vi), int'(busy), 0);
   endtask

   initial begin
      vecs[0] = '{r:3'd4, c:3'd4, allow:8'hFF, n:8, donecyc:16,
                  dirs:'{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
                  tgts:'{6'o23, 6'o25, 6'o36, 6'o56, 6'o65, 6'o63, 6'o52, 6'o32}};
      vecs[1] = '{r:3'd0, c:3'd0, allow:8'b0001_1000, n:2, donecyc:4,
                  dirs:'{3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                  tgts:'{6'o12, 6'o21, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0}};
      vecs[2] = '{r:3'd4, c:3'd4, allow:8'h00, n:0, donecyc:1,
                  dirs:'{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                  tgts:'{6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0}};
      vecs[3] = '{r:3'd0, c:3'd0, allow:8'hFF, n:2, donecyc:4,
                  dirs:'{3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                  tgts:'{6'o12, 6'o21, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0}};
      vecs[4] = '{r:3'd7, c:3'd7, allow:8'hFF, n:2, donecyc:4,
                  dirs:'{3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                  tgts:'{6'o56, 6'o65, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0}};
      vecs[5] = '{r:3'd0, c:3'd7, allow:8'h02, n:0, donecyc:1,
                  dirs:'{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                  tgts:'{6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0}};

      reset = 1'b1; start = 1'b0; row = '0; column = '0; knightAllow = '0;
      abort = 1'b0; occupied = 64'd1 << 19; mv_if.move_ready = 1'b0;
      repeat (2) tick;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset valid", int'(mv_if.move_valid), 0);
      chk("reset tgt", cur_tgt(), 0);
      chk("reset count", int'(move_count), 0);
      reset = 1'b0;
      tick;

      for (int i = 0; i < 6; i++) run_scan(i);

      // Back-pressure: target held while ready low; start pulses during SCAN ignored.
      row = 3'd4; column = 3'd4; knightAllow = 8'h81; mv_if.move_ready = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("hold valid", int'(mv_if.move_valid), 1);
         chk("hold dir", int'(mv_if.move_dir), 0);
         chk("hold tgt", cur_tgt(), int'(6'o23));
         if (i == 2) begin start = 1'b1; row = 3'd0; column = 3'd0; knightAllow = 8'hFF; end
         else start = 1'b0;
         tick;
      end
      knightAllow = 8'h00;
      mv_if.move_ready = 1'b1;
      tick;
      chk("hold gap valid", int'(mv_if.move_valid), 0);
      chk("hold gap busy", int'(busy), 1);
      tick;
      chk("hold second valid", int'(mv_if.move_valid), 1);
      chk("hold second dir", int'(mv_if.move_dir), 7);
      chk("hold second tgt", cur_tgt(), int'(6'o32));
      tick;
      chk("hold tail done", int'(done), 0);
      tick;
      chk("hold done", int'(done), 1);
      chk("hold count", int'(move_count), 2);
      tick;

      // Abort while the third move of the full-board scan is presented.
      row = 3'd4; column = 3'd4; knightAllow = 8'hFF; mv_if.move_ready = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0; knightAllow = 8'h00;
      repeat (4) tick;
      chk("abort third valid", int'(mv_if.move_valid), 1);
      chk("abort third dir", int'(mv_if.move_dir), 2);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort busy", int'(busy), 0);
      chk("abort valid", int'(mv_if.move_valid), 0);
      chk("abort done", int'(done), 0);
      chk("abort count", int'(move_count), 2);
      tick;
      chk("abort no late done", int'(done), 0);

      // Asynchronous reset in the middle of a scan.
      knightAllow = 8'hFF;
      start = 1'b1;
      tick;
      start = 1'b0; knightAllow = 8'h00;
      repeat (2) tick;
      chk("pre-reset dir", int'(mv_if.move_dir), 1);
      reset = 1'b1;
      #1;
      chk("async reset valid", int'(mv_if.move_valid), 0);
      chk("async reset busy", int'(busy), 0);
      chk("async reset done", int'(done), 0);
      chk("async reset dir", int'(mv_if.move_dir), 0);
      chk("async reset tgt", cur_tgt(), 0);
      chk("async reset count", int'(move_count), 0);
      #2;
      reset = 1'b0;
      tick;
      chk("post-reset valid", int'(mv_if.move_valid), 0);
      chk("post-reset busy", int'(busy), 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
